// File: rtl/lfsr_pkg.sv
// Register map, control bit indices and response codes for the multi-channel LFSR slave,
// plus the byte-lane merge helper used on every register write.
package lfsr_pkg;
    localparam logic [3:0] OFF_CTRL  = 4'h0;
    localparam logic [3:0] OFF_SEED  = 4'h4;
    localparam logic [3:0] OFF_TAPS  = 4'h8;
    localparam logic [3:0] OFF_STATE = 4'hC;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_STEP = 1;
    localparam int CTRL_LOAD = 2;

    localparam int CH_STRIDE = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return merged;
    endfunction
endpackage

// File: rtl/lfsr_chan.sv
// One Galois LFSR channel: SEED/TAPS/STATE storage, step/load sequencing and
// optional all-zero lockup recovery (LFSR_LOCKUP_RECOVER_EN).
module lfsr_chan
    import lfsr_pkg::*;
#(
    parameter int          LFSR_W       = 32,
    parameter logic [31:0] DEFAULT_TAPS = 32'h8020_0003
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              i_seed_we,
    input  logic              i_taps_we,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic              i_run,
    input  logic              i_step,
    input  logic              i_load,
    output logic [LFSR_W-1:0] o_seed,
    output logic [LFSR_W-1:0] o_taps,
    output logic [LFSR_W-1:0] o_state,
    output logic              o_lockup
);
    logic [LFSR_W-1:0] r_seed;
    logic [LFSR_W-1:0] r_taps;
    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_galois;
    logic [LFSR_W-1:0] w_state_next;
    logic              w_lockup;

    // LOAD wins over any step; RUN and STEP together still advance only once.
    always_comb begin
        w_galois     = (r_state >> 1) ^ (r_state[0] ? r_taps : '0);
        w_state_next = r_state;
        w_lockup     = 1'b0;
        if (i_load) begin
            w_state_next = r_seed;
        end else if (i_run || i_step) begin
            w_state_next = w_galois;
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (w_galois == '0) begin
                w_state_next = LFSR_W'(1);
                w_lockup     = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_seed  <= LFSR_W'(1);
            r_taps  <= DEFAULT_TAPS[LFSR_W-1:0];
            r_state <= LFSR_W'(1);
        end else begin
            r_state <= w_state_next;
            if (i_seed_we) begin
                r_seed <= LFSR_W'(apply_wstrb(32'(r_seed), i_wdata, i_wstrb));
            end
            if (i_taps_we) begin
                r_taps <= LFSR_W'(apply_wstrb(32'(r_taps), i_wdata, i_wstrb));
            end
        end
    end

    assign o_seed   = r_seed;
    assign o_taps   = r_taps;
    assign o_state  = r_state;
    assign o_lockup = w_lockup;
endmodule

// File: rtl/lfsr_axil_multi.sv
// AXI4-Lite slave exposing NUM_CH independent Galois LFSR channels plus a STATUS word.
// Build option: define LFSR_LOCKUP_RECOVER_EN for lockup recovery with sticky W1C STATUS.
module lfsr_axil_multi
    import lfsr_pkg::*;
#(
    parameter int          NUM_CH             = 4,
    parameter int          LFSR_W             = 32,
    parameter logic [31:0] DEFAULT_TAPS       = 32'h8020_0003,
    parameter int          C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [NUM_CH*LFSR_W-1:0]      lfsr_out
);
    localparam int            AW          = C_S_AXI_ADDR_WIDTH;
    localparam int            CHW         = AW - 4;
    localparam logic [AW-1:0] STATUS_ADDR = AW'(NUM_CH * CH_STRIDE);

    logic              r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]        r_bresp, r_rresp;
    logic [31:0]       r_rdata;
    logic [NUM_CH-1:0] r_status;

    logic              w_wr_fire, w_rd_fire;
    logic              w_aw_in_ch, w_aw_status, w_ar_in_ch, w_ar_status;
    logic [CHW-1:0]    w_aw_ch, w_ar_ch;
    logic [31:0]       w_rdata;
    logic [1:0]        w_rresp;
    logic [NUM_CH-1:0] w_run, w_lockup, w_status_clr;
    logic [LFSR_W-1:0] w_seed  [NUM_CH];
    logic [LFSR_W-1:0] w_taps  [NUM_CH];
    logic [LFSR_W-1:0] w_state [NUM_CH];
    logic              w_unused;

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT};

    assign w_wr_fire   = r_wready && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_aw_in_ch  = S_AXI_AWADDR < STATUS_ADDR;
    assign w_aw_status = S_AXI_AWADDR[AW-1:2] == STATUS_ADDR[AW-1:2];
    assign w_aw_ch     = S_AXI_AWADDR[AW-1:4];

    assign w_rd_fire   = r_arready && S_AXI_ARVALID;
    assign w_ar_in_ch  = S_AXI_ARADDR < STATUS_ADDR;
    assign w_ar_status = S_AXI_ARADDR[AW-1:2] == STATUS_ADDR[AW-1:2];
    assign w_ar_ch     = S_AXI_ARADDR[AW-1:4];

    // Ready is a registered one-cycle pulse, so the acceptance edge is the edge it is high.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_wready  <= !r_wready && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
            r_arready <= !r_arready && S_AXI_ARVALID && !r_rvalid;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= (w_aw_in_ch || w_aw_status) ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
                r_rresp  <= w_rresp;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        w_rresp = RESP_SLVERR;
        if (w_ar_status) begin
            w_rresp = RESP_OKAY;
            w_rdata = 32'(r_status);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ar_in_ch && (w_ar_ch == CHW'(c))) begin
                w_rresp = RESP_OKAY;
                case (S_AXI_ARADDR[3:2])
                    OFF_CTRL[3:2]: w_rdata = 32'(w_run[c]);
                    OFF_SEED[3:2]: w_rdata = 32'(w_seed[c]);
                    OFF_TAPS[3:2]: w_rdata = 32'(w_taps[c]);
                    default:       w_rdata = 32'(w_state[c]);
                endcase
            end
        end
    end

`ifdef LFSR_LOCKUP_RECOVER_EN
    assign w_status_clr = (w_wr_fire && w_aw_status && S_AXI_WSTRB[0]) ?
                          S_AXI_WDATA[NUM_CH-1:0] : '0;
`else
    assign w_status_clr = '0;
`endif

    // A lockup in the same cycle as a clear keeps the bit set.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_status_clr) | w_lockup;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic w_sel, w_ctrl_we;
        logic r_run, r_step, r_load;

        assign w_sel     = w_wr_fire && w_aw_in_ch && (w_aw_ch == CHW'(gi));
        assign w_ctrl_we = w_sel && (S_AXI_AWADDR[3:2] == OFF_CTRL[3:2]) && S_AXI_WSTRB[0];

        always_ff @(posedge ACLK) begin
            if (ARESET) begin
                r_run  <= 1'b0;
                r_step <= 1'b0;
                r_load <= 1'b0;
            end else begin
                r_step <= w_ctrl_we && S_AXI_WDATA[CTRL_STEP];
                r_load <= w_ctrl_we && S_AXI_WDATA[CTRL_LOAD];
                if (w_ctrl_we) begin
                    r_run <= S_AXI_WDATA[CTRL_RUN];
                end
            end
        end

        lfsr_chan #(
            .LFSR_W      (LFSR_W),
            .DEFAULT_TAPS(DEFAULT_TAPS)
        ) u_chan (
            .clk      (ACLK),
            .srst     (ARESET),
            .i_seed_we(w_sel && (S_AXI_AWADDR[3:2] == OFF_SEED[3:2])),
            .i_taps_we(w_sel && (S_AXI_AWADDR[3:2] == OFF_TAPS[3:2])),
            .i_wdata  (S_AXI_WDATA),
            .i_wstrb  (S_AXI_WSTRB),
            .i_run    (r_run),
            .i_step   (r_step),
            .i_load   (r_load),
            .o_seed   (w_seed[gi]),
            .o_taps   (w_taps[gi]),
            .o_state  (w_state[gi]),
            .o_lockup (w_lockup[gi])
        );

        assign w_run[gi] = r_run;
        assign lfsr_out[gi*LFSR_W +: LFSR_W] = w_state[gi];
    end

    assign S_AXI_AWREADY = r_wready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
endmodule

// File: tb/tb_lfsr_axil_multi.sv
// Self-checking bench for lfsr_axil_multi (4 channels, 8-bit LFSRs); B and R responses are
// checked by monitors against scoreboard queues filled when each transaction is driven.
module tb_lfsr_axil_multi;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
`ifdef LFSR_LOCKUP_RECOVER_EN
    localparam logic [31:0] EXP_LOCK = 32'h1;
`else
    localparam logic [31:0] EXP_LOCK = 32'h0;
`endif

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [6:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [31:0] lfsr_out;

    lfsr_axil_multi #(
        .NUM_CH(4), .LFSR_W(8), .DEFAULT_TAPS(32'h8020_0003), .C_S_AXI_ADDR_WIDTH(7)
    ) dut (
        .ACLK(aclk), .ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .lfsr_out(lfsr_out)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct { logic [6:0] addr; logic [1:0] resp; } bexp_t;
    typedef struct { logic [6:0] addr; logic [31:0] data; logic [1:0] resp; } rexp_t;
    typedef struct {
        bit          is_wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    bexp_t bq[$];
    rexp_t rq[$];
    vec_t  vt[40];
    int    nv = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    last_hs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no handshake within bound (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [7:0] mstep(input logic [7:0] s, input logic [7:0] t);
        logic [7:0] n;
        n = {1'b0, s[7:1]} ^ (s[0] ? t : 8'h00);
`ifdef LFSR_LOCKUP_RECOVER_EN
        if (n == 8'h00) n = 8'h01;
`endif
        return n;
    endfunction

    always @(negedge aclk) begin
        if (!areset && bvalid && bready) begin
            if (bq.size() == 0) begin
                timeout("b_unexpected");
            end else begin
                bexp_t e;
                e = bq.pop_front();
                chk($sformatf("bresp@%h", e.addr), 32'(bresp), 32'(e.resp));
                $display("B  addr=%h bresp=%0d", e.addr, bresp);
            end
        end
    end

    always @(negedge aclk) begin
        if (!areset && rvalid && rready) begin
            if (rq.size() == 0) begin
                timeout("r_unexpected");
            end else begin
                rexp_t e;
                e = rq.pop_front();
                chk($sformatf("rdata@%h", e.addr), rdata, e.data);
                chk($sformatf("rresp@%h", e.addr), 32'(rresp), 32'(e.resp));
                $display("R  addr=%h rdata=%h rresp=%0d", e.addr, rdata, rresp);
            end
        end
    end

    task automatic aw_issue(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (1) begin
            @(negedge aclk);
            if (awready && wready) break;
            n++;
            if (n > 40) begin timeout("aw_handshake"); break; end
        end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        last_hs = cyc;
    endtask

    task automatic wait_b();
        int n = 0;
        while (1) begin
            @(negedge aclk);
            if (bvalid && bready) break;
            n++;
            if (n > 40) begin timeout("b_handshake"); break; end
        end
        @(posedge aclk); #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] er);
        bexp_t e;
        e.addr = a; e.resp = er;
        bq.push_back(e);
        aw_issue(a, d, s);
        wait_b();
    endtask

    task automatic rd(input logic [6:0] a, input logic [31:0] ed, input logic [1:0] er);
        rexp_t e;
        int n = 0;
        e.addr = a; e.data = ed; e.resp = er;
        rq.push_back(e);
        araddr = a; arvalid = 1'b1;
        while (1) begin
            @(negedge aclk);
            if (arready) break;
            n++;
            if (n > 40) begin timeout("ar_handshake"); break; end
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        n = 0;
        while (1) begin
            @(negedge aclk);
            if (rvalid && rready) break;
            n++;
            if (n > 40) begin timeout("r_handshake"); break; end
        end
        @(posedge aclk); #1;
    endtask

    task automatic addv(input bit w, input logic [6:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er);
        vt[nv].is_wr = w; vt[nv].addr = a; vt[nv].data = d; vt[nv].strb = s;
        vt[nv].exp_data = ed; vt[nv].exp_resp = er;
        nv++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [7:0] m;
        int n;
        int hs_on;

        // Reset values, register write/read-back, lane strobes, truncation, error decode.
        addv(0, 7'h00, 0, 0, 32'h00, OKAY);
        addv(0, 7'h04, 0, 0, 32'h01, OKAY);
        addv(0, 7'h08, 0, 0, 32'h03, OKAY);
        addv(0, 7'h0C, 0, 0, 32'h01, OKAY);
        addv(0, 7'h40, 0, 0, 32'h00, OKAY);
        addv(0, 7'h7C, 0, 0, 32'h00, SLVERR);
        addv(0, 7'h44, 0, 0, 32'h00, SLVERR);
        for (int c = 0; c < 4; c++) begin
            addv(1, 7'(c*16 + 4), 32'(2*c + 1), 4'hF, 0, OKAY);
            addv(1, 7'(c*16 + 8), 32'(2*c + 2), 4'hF, 0, OKAY);
        end
        for (int c = 0; c < 4; c++) begin
            addv(0, 7'(c*16 + 4), 0, 0, 32'(2*c + 1), OKAY);
            addv(0, 7'(c*16 + 8), 0, 0, 32'(2*c + 2), OKAY);
        end
        addv(1, 7'h04, 32'hFF, 4'h0, 0, OKAY);
        addv(0, 7'h04, 0, 0, 32'h01, OKAY);
        addv(1, 7'h38, 32'h1234_5608, 4'hF, 0, OKAY);
        addv(0, 7'h38, 0, 0, 32'h08, OKAY);
        addv(1, 7'h0C, 32'h55, 4'hF, 0, OKAY);
        addv(0, 7'h0C, 0, 0, 32'h01, OKAY);
        addv(1, 7'h7C, 32'h1, 4'hF, 0, SLVERR);
        addv(1, 7'h50, 32'h1, 4'hF, 0, SLVERR);
        addv(0, 7'h10, 0, 0, 32'h00, OKAY);

        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        chk("rst_awready", 32'(awready), 0);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_bresp", 32'(bresp), 0);
        chk("rst_rresp", 32'(rresp), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_lfsr_out", lfsr_out, 32'h0101_0101);

        for (int i = 0; i < nv; i++) begin
            if (vt[i].is_wr) wr(vt[i].addr, vt[i].data, vt[i].strb, vt[i].exp_resp);
            else             rd(vt[i].addr, vt[i].exp_data, vt[i].exp_resp);
        end

        // Single stepping on ch0.
        wr(7'h08, 32'hB8, 4'hF, OKAY);
        wr(7'h04, 32'h01, 4'hF, OKAY);
        wr(7'h00, 32'h4, 4'hF, OKAY);
        rd(7'h0C, 32'h01, OKAY);
        wr(7'h00, 32'h2, 4'hF, OKAY);
        rd(7'h0C, 32'hB8, OKAY);
        wr(7'h00, 32'h2, 4'hF, OKAY);
        rd(7'h0C, 32'h5C, OKAY);
        chk("lfsr_out_ch0", 32'(lfsr_out[7:0]), 32'h5C);
        rd(7'h00, 32'h0, OKAY);
        wr(7'h04, 32'h37, 4'hF, OKAY);
        wr(7'h00, 32'h4, 4'hF, OKAY);
        rd(7'h0C, 32'h37, OKAY);

        // RUN for exactly 10 cycles: the RUN=0 write is timed to land 10 edges later.
        wr(7'h00, 32'h1, 4'hF, OKAY);
        hs_on = last_hs;
        repeat (7) @(posedge aclk);
        #1;
        wr(7'h00, 32'h0, 4'hF, OKAY);
        chk("run_window", 32'(last_hs - hs_on), 32'd10);
        m = 8'h37;
        for (int i = 0; i < 10; i++) m = mstep(m, 8'hB8);
        rd(7'h0C, 32'(m), OKAY);
        rd(7'h1C, 32'h01, OKAY);
        rd(7'h2C, 32'h01, OKAY);
        rd(7'h3C, 32'h01, OKAY);

        // Lockup: taps 0 drives state to zero on the first step.
        wr(7'h08, 32'h00, 4'hF, OKAY);
        wr(7'h04, 32'h01, 4'hF, OKAY);
        wr(7'h00, 32'h4, 4'hF, OKAY);
        rd(7'h0C, 32'h01, OKAY);
        wr(7'h00, 32'h2, 4'hF, OKAY);
        rd(7'h0C, EXP_LOCK, OKAY);
        rd(7'h40, EXP_LOCK, OKAY);
        wr(7'h40, 32'h0, 4'hF, OKAY);
        rd(7'h40, EXP_LOCK, OKAY);
        wr(7'h40, 32'h1, 4'hF, OKAY);
        rd(7'h40, 32'h0, OKAY);

        // Backpressure: BVALID holds while BREADY is low and a second write is not accepted.
        bready = 1'b0;
        begin
            bexp_t e;
            e.addr = 7'h14; e.resp = OKAY;
            bq.push_back(e);
        end
        aw_issue(7'h14, 32'h11, 4'hF);
        awaddr = 7'h18; wdata = 32'h22; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk($sformatf("bp_bvalid_%0d", i), 32'(bvalid), 1);
            chk($sformatf("bp_awready_%0d", i), 32'(awready), 0);
        end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        wait_b();
        rd(7'h14, 32'h11, OKAY);
        rd(7'h18, 32'h04, OKAY);

        // Reset while a read response is pending.
        rready = 1'b0;
        araddr = 7'h14; arvalid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge aclk);
            if (arready) break;
            n++;
            if (n > 40) begin timeout("ar_before_reset"); break; end
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        @(negedge aclk);
        chk("pend_rvalid", 32'(rvalid), 1);
        @(posedge aclk); #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        chk("abort_rvalid", 32'(rvalid), 0);
        chk("abort_lfsr_out", lfsr_out, 32'h0101_0101);
        areset = 1'b0;
        rready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("abort_rvalid_later", 32'(rvalid), 0);
        rd(7'h14, 32'h01, OKAY);
        rd(7'h08, 32'h03, OKAY);
        rd(7'h0C, 32'h01, OKAY);
        rd(7'h00, 32'h00, OKAY);
        rd(7'h40, 32'h00, OKAY);

        // Simultaneous write and read to the same register; read returns the pre-write value.
        begin
            bexp_t be;
            rexp_t re;
            be.addr = 7'h24; be.resp = OKAY;
            re.addr = 7'h24; re.data = 32'h01; re.resp = OKAY;
            bq.push_back(be);
            rq.push_back(re);
        end
        awaddr = 7'h24; wdata = 32'h5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 7'h24; arvalid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge aclk);
            if (awready || arready) break;
            n++;
            if (n > 40) begin timeout("simul_handshake"); break; end
        end
        chk("simul_awready", 32'(awready), 1);
        chk("simul_arready", 32'(arready), 1);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        rd(7'h24, 32'h5A, OKAY);

        chk("bq_drained", 32'(bq.size()), 0);
        chk("rq_drained", 32'(rq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lfsr_axil_multi.md
LFSR_AXIL_MULTI -- requirements
Module: lfsr_axil_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent LFSR channels (1..8).
REQ-002 SHALL have parameter LFSR_W, default 32, meaning LFSR state width in bits (4..32).
REQ-003 SHALL have parameter DEFAULT_TAPS, default 32'h8020_0003, meaning the reset tap mask, truncated to LFSR_W.
REQ-004 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 7, meaning AXI address width; it SHALL be at least clog2((NUM_CH+1)*16).
REQ-005 SHALL have port ACLK, input, 1 bit: the single clock. All logic is clocked on its rising edge.
REQ-006 SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port group S_AXI_AWADDR/AWPROT/AWVALID/AWREADY: AXI4-Lite write address channel, widths ADDR/3/1/1.
REQ-008 SHALL have port group S_AXI_WDATA/WSTRB/WVALID/WREADY: AXI4-Lite write data channel, widths 32/4/1/1.
REQ-009 SHALL have port group S_AXI_BRESP/BVALID/BREADY: AXI4-Lite write response channel, widths 2/1/1.
REQ-010 SHALL have port group S_AXI_ARADDR/ARPROT/ARVALID/ARREADY: AXI4-Lite read address channel, widths ADDR/3/1/1.
REQ-011 SHALL have port group S_AXI_RDATA/RRESP/RVALID/RREADY: AXI4-Lite read data channel, widths 32/2/1/1.
REQ-012 SHALL have port lfsr_out, output, NUM_CH*LFSR_W bits: live state of every channel.

Function
REQ-013 Register map SHALL place channel c at base c*0x10 with four registers:
- +0x0 CTRL: bit0 RUN (read/write); bit1 STEP (write-1, self-clearing, reads 0); bit2 LOAD (write-1, self-clearing, reads 0).
- +0x4 SEED (read/write).
- +0x8 TAPS (read/write).
- +0xC STATE (read-only; writes ignored, response OKAY).
REQ-014 STATUS SHALL be at NUM_CH*0x10; any address beyond it SHALL return SLVERR, with writes ignored and read data 0.
REQ-015 Write data SHALL be truncated to LFSR_W; reads SHALL be zero-extended; WSTRB byte lanes SHALL be honoured.
REQ-016 Each step SHALL compute next = (state >> 1) ^ (state[0] ? taps : 0) (Galois form), masked to LFSR_W.
REQ-017 State SHALL step every cycle while RUN=1, and exactly once in the cycle after a STEP write.
REQ-018 LOAD SHALL set state to SEED one cycle after the write.
REQ-019 Priority SHALL be LOAD > STEP/RUN step > hold; STEP issued while RUN=1 SHALL produce only one step in that cycle.
REQ-020 Write handshake SHALL be as follows:
- AWREADY and WREADY assert together for one cycle when AWVALID && WVALID && !BVALID.
- BVALID asserts the next cycle and holds until BREADY.
REQ-021 Read handshake SHALL be as follows:
- ARREADY pulses one cycle when ARVALID && !RVALID.
- RVALID asserts the next cycle and holds until RREADY.
- RDATA captures the register value of the acceptance cycle (pre-update if a step coincides).
REQ-022 The slave SHALL accept a new read and a new write in the same cycle without interaction.
REQ-023 A SEED or TAPS write coinciding with a step SHALL take effect for subsequent steps only.

Reset
REQ-024 On ARESET, the block SHALL enter the following reset state:
- CTRL=0, SEED=1, STATE=1, TAPS=DEFAULT_TAPS, STATUS=0.
- All VALID/READY outputs 0; BRESP/RRESP=0; RDATA=0.
REQ-025 Reset asserted mid-transaction SHALL abort that transaction; no response SHALL be issued afterwards.

Configuration
REQ-026 Macro LFSR_LOCKUP_RECOVER_EN defined: a step producing all-zero state SHALL instead load 1 and set sticky STATUS[c]; STATUS bits SHALL be write-1-to-clear.
REQ-027 Macro LFSR_LOCKUP_RECOVER_EN undefined: the state SHALL remain zero, and STATUS SHALL read 0 and ignore writes.

Structure
REQ-028 Package lfsr_pkg SHALL hold the register offsets, CTRL bit indices, the channel stride constant and the RESP_OKAY/RESP_SLVERR constants.
REQ-029 One sub-module, lfsr_chan, SHALL be instantiated NUM_CH times; it holds SEED/TAPS/STATE and the step/load/lockup logic.

Verification
REQ-030 Bench SHALL cover the following directed scenarios (LFSR_W=8):
- Write/read-back: write SEED/TAPS of all 4 channels with 0x01..0x08 -> read back equal, BRESP=RRESP=OKAY.
- Single stepping: ch0 TAPS=0xB8, SEED=0x01, LOAD -> STATE=0x01; STEP -> 0xB8; STEP -> 0x5C.
- RUN mode: RUN=1 for exactly 10 cycles, then RUN=0 -> STATE equals 10 reference-model steps; ch1..3 unchanged.
- Lockup: TAPS=0x00, SEED=0x01, LOAD, STEP -> with macro, STATE=0x01 and STATUS=0x1, and W1C 0x1 -> STATUS=0; without macro, STATE=0x00 and STATUS=0.
- Errors and backpressure: read 0x7C -> RRESP=SLVERR, RDATA=0; BREADY held low 5 cycles -> BVALID stays high, no second AWREADY.
- Reset and transaction independence: ARESET during pending RVALID -> RVALID=0 next cycle and all registers at reset values; simultaneous write and read accepted in the same cycle.
